// File: rtl/bist_controller.sv
// Built-in self-test controller: an LFSR drives pseudo-random patterns into a netlist,
// and a MISR compresses the responses into a signature that is compared with GOLDEN.
module bist_controller #(
  parameter int                    WIDTH        = 8,
  parameter int                    RESP_WIDTH   = 8,
  parameter logic [WIDTH-1:0]      TAPS         = 8'b10111000,
  parameter logic [RESP_WIDTH-1:0] MISR_TAPS    = 8'b10111000,
  parameter logic [WIDTH-1:0]      LFSR_SEED    = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [RESP_WIDTH-1:0] MISR_SEED    = {RESP_WIDTH{1'b0}},
  parameter int                    NUM_PATTERNS = 255,
  parameter int                    SETTLE       = 1,
  parameter logic [RESP_WIDTH-1:0] GOLDEN       = {RESP_WIDTH{1'b0}}
) (
  input  logic                              C,
  input  logic                              R,
  input  logic                              start,
  input  logic [RESP_WIDTH-1:0]             response,
  output logic [WIDTH-1:0]                  pattern,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [RESP_WIDTH-1:0]             signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0] count
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF =
    (LFSR_SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    APPLY   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ^(v & TAPS)};
  endfunction

  function automatic logic [RESP_WIDTH-1:0] misr_step(input logic [RESP_WIDTH-1:0] v,
                                                      input logic [RESP_WIDTH-1:0] rsp);
    return {v[RESP_WIDTH-2:0], ^(v & MISR_TAPS)} ^ rsp;
  endfunction

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        lfsr_q, lfsr_d;
  logic [RESP_WIDTH-1:0]   misr_q, misr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic                    pass_q, pass_d;
  logic [RESP_WIDTH-1:0]   misr_next_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge C) begin
    if (R) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      misr_q   <= MISR_SEED;
      count_q  <= {CW{1'b0}};
      settle_q <= {SW{1'b0}};
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      count_q  <= count_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
    end
  end

  assign misr_next_s = misr_step(misr_q, response);

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    count_d  = count_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = APPLY;
          lfsr_d   = SEED_EFF;
          misr_d   = MISR_SEED;
          count_d  = {CW{1'b0}};
          settle_d = {SW{1'b0}};
          pass_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      APPLY: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d  = CAPTURE;
          settle_d = {SW{1'b0}};
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      CAPTURE: begin
        misr_d  = misr_next_s;
        count_d = count_q + CW'(1);
        // The final pattern stays on the bus; pass is judged on the updated signature.
        if (count_q == CW'(NUM_PATTERNS - 1)) begin
          state_d = DONE;
          pass_d  = (misr_next_s == GOLDEN);
        end else begin
          state_d = APPLY;
          lfsr_d  = lfsr_step(lfsr_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pattern   = lfsr_q;
  assign busy      = (state_q == APPLY) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = misr_q;
  assign count     = count_q;

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller: 4-bit LFSR/MISR (taps 1001), response looped
// back from pattern; expected values are hand-derived and queued at stimulus time.
module tb_bist_controller;

  logic C = 1'b0;
  always #5 C = ~C;

  logic       R = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       force_zero = 1'b0;
  logic [3:0] pat_a, sig_a, rsp_a, pat_b, sig_b, pat_c, sig_c;
  logic [1:0] cnt_a, cnt_c;
  logic [3:0] cnt_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;

  assign rsp_a = force_zero ? 4'h0 : pat_a;

  bist_controller #(.WIDTH(4), .RESP_WIDTH(4), .TAPS(4'b1001), .MISR_TAPS(4'b1001),
    .LFSR_SEED(4'h1), .MISR_SEED(4'h0), .NUM_PATTERNS(3), .SETTLE(1), .GOLDEN(4'h7)) dut_a (
    .C(C), .R(R), .start(start_a), .response(rsp_a), .pattern(pat_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a), .count(cnt_a));

  bist_controller #(.WIDTH(4), .RESP_WIDTH(4), .TAPS(4'b1001), .MISR_TAPS(4'b1001),
    .LFSR_SEED(4'h1), .MISR_SEED(4'h0), .NUM_PATTERNS(15), .SETTLE(1), .GOLDEN(4'h0)) dut_b (
    .C(C), .R(R), .start(start_b), .response(pat_b), .pattern(pat_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b), .count(cnt_b));

  bist_controller #(.WIDTH(4), .RESP_WIDTH(4), .TAPS(4'b1001), .MISR_TAPS(4'b1001),
    .LFSR_SEED(4'h0), .MISR_SEED(4'h0), .NUM_PATTERNS(3), .SETTLE(1), .GOLDEN(4'h7)) dut_c (
    .C(C), .R(R), .start(start_c), .response(pat_c), .pattern(pat_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .signature(sig_c), .count(cnt_c));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int b_done_edge = 0;

  typedef struct { int cnt; logic [3:0] sig; } cap_t;
  typedef struct { int edge_no; logic p; logic [3:0] sig; } done_t;
  cap_t       cap_q[$];
  done_t      done_q[$];
  logic [3:0] pat_exp_q[$];

  always @(posedge C) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor A: every capture and every done rise is checked against the queues.
  initial begin
    logic [1:0] prev_cnt;
    logic       prev_done;
    cap_t       ce;
    done_t      de;
    prev_cnt  = 2'd0;
    prev_done = 1'b0;
    forever begin
      @(negedge C);
      if (mon_en) begin
        if (cnt_a != prev_cnt && cnt_a != 2'd0) begin
          if (cap_q.size() == 0) check("a_cap_unexpected", 1, 0);
          else begin
            ce = cap_q.pop_front();
            check("a_cap_count", int'(cnt_a), ce.cnt);
            check("a_cap_sig", int'(sig_a), int'(ce.sig));
          end
        end
        if (done_a && !prev_done) begin
          if (done_q.size() == 0) check("a_done_unexpected", 1, 0);
          else begin
            de = done_q.pop_front();
            check("a_done_edge", cyc, de.edge_no);
            check("a_pass", int'(pass_a), int'(de.p));
            check("a_final_sig", int'(sig_a), int'(de.sig));
            check("a_final_count", int'(cnt_a), 3);
            check("a_busy_in_done", int'(busy_a), 0);
          end
        end
      end
      prev_cnt  = cnt_a;
      prev_done = done_a;
    end
  end

  // Monitor B: pattern sequence, hold length per pattern and run latency.
  initial begin
    logic       prev_busy, prev_done;
    logic [3:0] prev_pat, ep;
    int         hold;
    prev_busy = 1'b0; prev_done = 1'b0; prev_pat = 4'h0; hold = 0;
    forever begin
      @(negedge C);
      if (mon_en) begin
        if (busy_b) begin
          if (!prev_busy || pat_b != prev_pat) begin
            if (prev_busy) check("b_hold", hold, 2);
            if (pat_exp_q.size() == 0) check("b_pat_unexpected", int'(pat_b), 16);
            else begin
              ep = pat_exp_q.pop_front();
              check("b_pattern", int'(pat_b), int'(ep));
            end
            hold = 1;
          end else begin
            hold++;
          end
        end
        if (done_b && !prev_done) begin
          check("b_hold_last", hold, 2);
          check("b_done_edge", cyc, b_done_edge);
          check("b_count", int'(cnt_b), 15);
          check("b_patterns_left", pat_exp_q.size(), 0);
        end
      end
      prev_busy = busy_b;
      prev_done = done_b;
      prev_pat  = pat_b;
    end
  end

  task automatic issue_start_a(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                               input logic p, input bit full, output int t0);
    @(negedge C);
    start_a = 1'b1;
    t0 = cyc + 1;
    cap_q.push_back('{1, s1});
    if (full) begin
      cap_q.push_back('{2, s2});
      cap_q.push_back('{3, s3});
      done_q.push_back('{t0 + 6, p, s3});
    end
    @(negedge C);
    start_a = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int max_cyc, input string name);
    int n = 0;
    while (!((sel == 0) ? done_a : (sel == 1) ? done_b : done_c) && n < max_cyc) begin
      @(negedge C);
      n++;
    end
    if (!((sel == 0) ? done_a : (sel == 1) ? done_b : done_c)) check(name, 0, 1);
  endtask

  initial begin
    int t0;
    logic [3:0] seq [15];
    seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    repeat (3) @(posedge C);
    @(negedge C);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_pass", int'(pass_a), 0);
    check("rst_pattern", int'(pat_a), 1);
    check("rst_sig", int'(sig_a), 0);
    check("rst_count", int'(cnt_a), 0);
    check("rst_zero_seed_pattern", int'(pat_c), 1);
    R = 1'b0;
    mon_en = 1'b1;

    // Free-running 15-pattern sequence.
    @(negedge C);
    start_b = 1'b1;
    b_done_edge = cyc + 1 + 30;
    for (int i = 0; i < 15; i++) pat_exp_q.push_back(seq[i]);
    @(negedge C);
    start_b = 1'b0;
    wait_done(1, 60, "b_done_timeout");

    // Three patterns, looped-back response.
    issue_start_a(4'h1, 4'h0, 4'h7, 1'b1, 1'b1, t0);
    wait_done(0, 20, "a_done_timeout_1");

    // Response forced to zero, started from DONE.
    force_zero = 1'b1;
    issue_start_a(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, t0);
    wait_done(0, 20, "a_done_timeout_2");
    force_zero = 1'b0;

    // Start pulsed mid-run is ignored.
    issue_start_a(4'h1, 4'h0, 4'h7, 1'b1, 1'b1, t0);
    check("a_restart_done_cleared", int'(done_a), 0);
    check("a_restart_pattern", int'(pat_a), 1);
    check("a_restart_count", int'(cnt_a), 0);
    check("a_restart_busy", int'(busy_a), 1);
    @(negedge C);
    start_a = 1'b1;
    @(negedge C);
    start_a = 1'b0;
    wait_done(0, 20, "a_done_timeout_3");

    // Second run from DONE reproduces the signature.
    issue_start_a(4'h1, 4'h0, 4'h7, 1'b1, 1'b1, t0);
    wait_done(0, 20, "a_done_timeout_4");

    // Reset during the CAPTURE cycle of pattern 2.
    issue_start_a(4'h1, 4'h0, 4'h7, 1'b1, 1'b0, t0);
    while (cyc < t0 + 3) @(negedge C);
    R = 1'b1;
    @(negedge C);
    R = 1'b0;
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_done", int'(done_a), 0);
    check("mid_rst_pattern", int'(pat_a), 1);
    check("mid_rst_sig", int'(sig_a), 0);
    check("mid_rst_count", int'(cnt_a), 0);
    issue_start_a(4'h1, 4'h0, 4'h7, 1'b1, 1'b1, t0);
    wait_done(0, 20, "a_done_timeout_5");

    // Zero LFSR seed behaves as seed 1.
    @(negedge C);
    start_c = 1'b1;
    @(negedge C);
    start_c = 1'b0;
    wait_done(2, 20, "c_done_timeout");
    check("c_sig", int'(sig_c), 7);
    check("c_pass", int'(pass_c), 1);
    check("c_count", int'(cnt_c), 3);

    repeat (2) @(negedge C);
    check("cap_queue_left", cap_q.size(), 0);
    check("done_queue_left", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Self-test stage that sits directly around a gate-level netlist mapped onto the team's CMOS cell set (BUF/NOT/NAND/NOR/DFF). Used by both synthesized designs and the sim bench.
- Drives LFSR pseudo-random patterns into the netlist inputs and compresses the netlist outputs in a MISR.
- After a fixed pattern count, compares the signature against a golden value and reports pass/fail.

Parameters:
- WIDTH, 8, pattern width (>=2)
- RESP_WIDTH, 8, response width (>=2)
- TAPS, 8'b10111000, LFSR feedback mask, WIDTH bits
- MISR_TAPS, 8'b10111000, MISR feedback mask, RESP_WIDTH bits
- LFSR_SEED, 1, initial LFSR value; 0 is replaced by 1
- MISR_SEED, 0, initial MISR value
- NUM_PATTERNS, 255, patterns per run (>=1)
- SETTLE, 1, cycles each pattern is held before capture (>=1); covers cell #1 delays
- GOLDEN, 0, expected signature, RESP_WIDTH bits

Ports:
- C  in  1  clock, rising edge
- R  in  1  reset, synchronous, active-high
- start  in  1  begin run; sampled in IDLE or DONE only
- response  in  RESP_WIDTH  netlist outputs
- pattern  out  WIDTH  netlist inputs; equals the LFSR register
- busy  out  1  high in APPLY/CAPTURE
- done  out  1  high in DONE
- pass  out  1  valid when done=1
- signature  out  RESP_WIDTH  current MISR register
- count  out  $clog2(NUM_PATTERNS+1)  patterns captured this run

Behaviour:
- Reset: R=1 at a rising edge forces the following, regardless of state (also mid-run):
  - state=IDLE, lfsr=seed (LFSR_SEED, or 1 if LFSR_SEED==0), misr=MISR_SEED
  - count=0, settle counter=0, busy=0, done=0, pass=0
- LFSR step: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- MISR step: misr <= {misr[RESP_WIDTH-2:0], ^(misr & MISR_TAPS)} ^ response.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs.
- State IDLE:
  - start=1 -> reload lfsr seed, misr=MISR_SEED, count=0, settle=0; go to APPLY.
- State APPLY:
  - pattern is held stable; settle increments each cycle.
  - When settle==SETTLE-1 -> go to CAPTURE and clear settle.
- State CAPTURE:
  - On the exiting edge, apply the MISR step using the response, and count++.
  - If count was NUM_PATTERNS-1 -> go to DONE; lfsr does not advance.
  - Otherwise step the LFSR and return to APPLY.
- State DONE:
  - done=1; pass=(misr==GOLDEN), registered on entry.
  - Held indefinitely.
  - start=1 -> behaves exactly as start in IDLE; done and pass clear on the same edge.
- Latency: start is sampled at edge E0. done rises at edge E0 + NUM_PATTERNS*(SETTLE+1).
- Each pattern is presented for exactly SETTLE+1 cycles.
- start is ignored while busy=1.
- When start and R are both high, R wins.
- count never exceeds NUM_PATTERNS.
- The LFSR never reaches the all-zero state (seed substitution).
- The LFSR wraps naturally when NUM_PATTERNS exceeds its period; no special handling.
- response is sampled only on the CAPTURE exit edge. Its value in other cycles has no effect.

Test Plan:
Common setup: WIDTH=RESP_WIDTH=4, TAPS=MISR_TAPS=4'b1001, LFSR_SEED=1, MISR_SEED=0, SETTLE=1, response wired to pattern.
1. Free-run, NUM_PATTERNS=15 -> pattern sequence 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8. Each value is held 2 cycles; no value repeats and 0 never appears.
2. NUM_PATTERNS=3, GOLDEN=4'h7:
   - Signature after each capture: 1, 0, 7.
   - done rises 6 edges after start; pass=1, count=3, busy=0.
3. Same as scenario 2 but response forced to 4'h0 -> signature 0, done after 6 edges, pass=0.
4. Start pulsed again at cycle 3 of the run in scenario 2 -> ignored; done still at edge 6.
   - In DONE, start=1 -> done=0 on the next edge, pattern=1, count=0.
   - The second run ends with the same signature 7.
5. R=1 in the CAPTURE cycle of pattern 2 -> next edge: IDLE, busy=0, pattern=1, signature=0, count=0.
   - A fresh start then reproduces scenario 2 exactly.
6. LFSR_SEED=0 -> after reset pattern=4'h1. The run in scenario 2 gives an identical signature 7.
